// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the IMEM boot loader: FSM encodings, frame field sizes
// and checksum width.
package imem_boot_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int CSUM_W         = 8;

  // States in which the loader is consuming frame bytes.
  function automatic logic accepts_bytes(input logic [2:0] st);
    return st inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs four consecutive bytes into one little-endian 32-bit word and flags
// the cycle in which the fourth byte arrives.
module imem_boot_loader_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [23:0]      lo_q, lo_d;

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    lo_d  = lo_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 1'b1;
      case (idx_q)
        2'd0:    lo_d[7:0]   = byte_i;
        2'd1:    lo_d[15:8]  = byte_i;
        2'd2:    lo_d[23:16] = byte_i;
        default: ;
      endcase
    end
  end

  // The top byte bypasses the buffer so the word is ready in the cycle it completes.
  assign word_valid_o = byte_valid_i & ~clear_i & (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_o       = {byte_i, lo_q};

  // NOTE: sequential state uses non-blocking assignments; the small byte buffer is
  // reset as well so the assembled word is never X, even though idx_q alone gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      lo_q  <= '0;
    end else begin
      idx_q <= idx_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length/data/checksum byte frame, writes the packed words into IMEM
// and releases the core from reset only after the checksum verifies.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_q, core_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              word_valid;
  logic [31:0]       word;
  logic [LEN_W:0]    len_full;
  logic [LEN_W:0]    words_next;

  assign rx_ready = accepts_bytes(state_q) & ~load_req;
  assign xfer     = rx_valid & rx_ready;

  imem_boot_loader_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (load_req),
    .byte_valid_i (xfer && (state_q == ST_DATA)),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Widened by one bit so N == DEPTH compares correctly at every ADDR_W.
  assign len_full   = {1'b0, rx_data, len_q[7:0]};
  assign words_next = (LEN_W + 1)'(words_q) + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    core_d  = core_q;
    done_d  = done_q;
    err_d   = err_q;

    if (word_valid) begin
      we_d    = 1'b1;
      addr_d  = words_q[ADDR_W-1:0];
      wdata_d = word;
      words_d = words_q + 1'b1;
    end

    if (load_req && (state_q != ST_IDLE)) begin
      state_d = ST_LEN0;
      csum_d  = '0;
      words_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      core_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_LEN0;
        ST_LEN0: if (xfer) begin
          len_d[7:0] = rx_data;
          csum_d     = csum_q ^ rx_data;
          state_d    = ST_LEN1;
        end
        ST_LEN1: if (xfer) begin
          len_d[LEN_W-1:8] = rx_data;
          csum_d           = csum_q ^ rx_data;
          if (len_full > (LEN_W + 1)'(DEPTH)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            core_d  = 1'b0;
          end else if (len_full == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (word_valid && (words_next == {1'b0, len_q})) state_d = ST_CSUM;
        end
        ST_CSUM: if (xfer) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            core_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            core_d  = 1'b0;
          end
        end
        ST_DONE, ST_ERROR: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      core_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      core_q  <= core_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst_n   = core_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus random frames compared
// against a frame-level reference model of expected IMEM writes and flags.
module tb_imem_boot_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WR_W   = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_req;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    fr_q[$];
  logic [WR_W-1:0] wr_q[$];
  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] pre_q[$];
  logic          exp_done;
  logic          exp_err;
  int            exp_words;
  bit            gap_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every IMEM write strobe observed, as {addr, data}.
  always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});

  // Reference: decode the frame in fr_q (possibly truncated) into writes and flags.
  task automatic model_frame();
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    if (fr_q.size() < 2) return;
    n = {fr_q[1], fr_q[0]};
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (fr_q.size() >= 2 + 4 * w + 4) begin
        exp_q.push_back({ADDR_W'(w), fr_q[2+4*w+3], fr_q[2+4*w+2], fr_q[2+4*w+1], fr_q[2+4*w]});
        exp_words++;
      end
    end
    if (fr_q.size() == 2 + 4 * n + 1) begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x = x ^ fr_q[i];
      if (x == fr_q[2+4*n]) exp_done = 1'b1;
      else exp_err = 1'b1;
    end
  endtask

  task automatic set_frame1(input logic [7:0] csum);
    fr_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, csum};
  endtask

  task automatic gen_random(input int n, input bit good);
    logic [7:0] x;
    fr_q.delete();
    fr_q.push_back(8'(n));
    fr_q.push_back(8'(n >> 8));
    if (n > DEPTH) return;
    for (int i = 0; i < 4 * n; i++) fr_q.push_back(8'($urandom));
    x = 8'h00;
    foreach (fr_q[i]) x = x ^ fr_q[i];
    if (!good) x = x ^ 8'($urandom_range(1, 255));
    fr_q.push_back(x);
  endtask

  // Called just after a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame();
    foreach (fr_q[i]) send_byte(fr_q[i]);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) check({tag, "_wr"}, wr_q[i], exp_q[i]);
  endtask

  task automatic check_final(input string tag);
    repeat (3) @(negedge clk);
    check_writes(tag);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_core_rst_n"}, core_rst_n, exp_done);
    check({tag, "_words"}, words_loaded, exp_words);
    check({tag, "_rx_ready"}, rx_ready, !(exp_done || exp_err));
  endtask

  // Fresh load of the frame in fr_q, including the flag latency after the last byte.
  task automatic run_frame(input string tag);
    pulse_load();
    wr_q.delete();
    model_frame();
    send_frame();
    check({tag, "_flag_latency"}, {done, error}, {exp_done, exp_err});
    check_final(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_words"}, words_loaded, 0);
    check({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    gap_en   = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_rx_ready", rx_ready, 0);
    @(negedge clk);
    #1;
    check("len0_rx_ready", rx_ready, 1);

    set_frame1(8'h92);
    run_frame("frame1");

    set_frame1(8'h93);
    run_frame("bad_csum");

    fr_q = '{8'h11, 8'h00};
    run_frame("oversize");

    fr_q = '{8'h00, 8'h00, 8'h00};
    run_frame("empty");

    gap_en = 1'b1;
    set_frame1(8'h92);
    run_frame("gaps");
    gap_en = 1'b0;

    // Abort after five data bytes; a byte offered during load_req must be ignored.
    pulse_load();
    wr_q.delete();
    set_frame1(8'h92);
    fr_q = fr_q[0:6];
    model_frame();
    pre_q = exp_q;
    send_frame();
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    #1;
    check("abort_rx_ready", rx_ready, 0);
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("abort_words", words_loaded, 0);
    check("abort_rx_ready_after", rx_ready, 1);
    set_frame1(8'h92);
    model_frame();
    exp_q = {pre_q, exp_q};
    send_frame();
    check_final("restart");

    // load_req while DONE drops the core back into reset on the next cycle.
    check("pre_reload_done", done, 1);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    #1;
    check("reload_core_rst_n", core_rst_n, 0);
    check("reload_done", done, 0);
    check("reload_words", words_loaded, 0);
    check("reload_rx_ready", rx_ready, 1);

    // Asynchronous reset in the middle of DATA.
    set_frame1(8'h92);
    fr_q = fr_q[0:7];
    send_frame();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_idle_rx_ready", rx_ready, 0);
    @(negedge clk);
    set_frame1(8'h92);
    model_frame();
    send_frame();
    check_final("after_reset");

    // Random frames; first one fills the whole memory.
    for (int it = 0; it < 10; it++) begin
      int n;
      n = (it == 0) ? DEPTH : $urandom_range(0, DEPTH + 2);
      gen_random(n, (it == 0) || ($urandom_range(0, 3) != 0));
      gap_en = bit'($urandom_range(0, 1));
      run_frame("random");
    end
    gap_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
